verificador_tabuleiro_seq: RTL and testbench
============================================

# verificador_tabuleiro_seq

Sequencer that reads one 3x3 micro-board from the shared board RAM, one cell per cycle, then scans the 8 winning lines and reports winner or draw. It sits between the game control unit and the board RAM. The control unit pulses `inicia` in its macro-verification step and waits for `pronto` before writing the board-state result.

## Interface
Parameters:
- `ADDR_W`, 7: board RAM address width (81 cells).
- `CELL_W`, 2: cell code width.

Ports:
- `clock`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-low; low forces the idle state immediately.
- `inicia`  in  1: start request, sampled only in ESPERA.
- `macro_idx`  in  4: micro-board index 0..8, latched when `inicia` is accepted.
- `ram_addr`  out  ADDR_W: cell address, `macro_idx*9 + k`.
- `ram_re`  out  1: read enable; the RAM is synchronous with 1-cycle read latency.
- `ram_dado`  in  CELL_W: cell code. 00 empty, 01 X, 10 O, 11 treated as empty.
- `ocupado`  out  1: high in every state except ESPERA.
- `pronto`  out  1: one-cycle pulse in FIM.
- `vencedor`  out  2: 00 none, 01 X, 10 O. Held until the next accepted `inicia`.
- `empate`  out  1: board full and no winner. Held like `vencedor`.
- `erro`  out  1: `macro_idx` was greater than 8. Held like `vencedor`.
- `db_estado`  out  3: current state code, for debug.

## Operation
- States, in encoding order 0..4:
  - ESPERA (0): idle.
  - LE (1): issues addresses.
  - DRENA (2): captures the last cell.
  - AVALIA (3): scans lines.
  - FIM (4): result ready.
- ESPERA → LE on `inicia`=1 with `macro_idx`≤8.
  - On that edge: latch base = `macro_idx*9` (computed as `(idx<<3)+idx`, ADDR_W bits), clear the cell counter, clear `vencedor`, `empate` and `erro`.
- ESPERA → FIM on `inicia`=1 with `macro_idx`>8. Sets `erro`=1 and `vencedor`=00; no RAM access.
- LE: for cycle k=0..8, drive `ram_re`=1 and `ram_addr`=base+k.
  - From k≥1, capture `ram_dado` into cell register k-1.
  - After k=8, go to DRENA.
- DRENA: `ram_re`=0; capture cell 8; go to AVALIA with line index 0.
- AVALIA: evaluate one line per cycle, j=0..7, in this order:
  - Rows: (0,1,2), (3,4,5), (6,7,8).
  - Columns: (0,3,6), (1,4,7), (2,5,8).
  - Diagonals: (0,4,8), (2,4,6).
  - A line wins when all three codes are equal and are 01 or 10. On the first win, register `vencedor` and go to FIM (early exit).
  - After j=7 with no win, go to FIM with `vencedor`=00.
- FIM: `pronto`=1 for exactly one cycle, then ESPERA.
- `inicia` outside ESPERA is ignored; there is no queuing.
- Code 11 is treated as empty for both win and full-board checks.

## Timing
- Reset values:
  - state ESPERA, `ram_addr`=0, `ram_re`=0, `ocupado`=0, `pronto`=0.
  - `vencedor`=00, `empate`=0, `erro`=0.
  - cell registers cleared, `db_estado`=0.
- Cycle numbering, with `inicia` accepted at cycle 0 (ESPERA):
  - LE: cycles 1–9.
  - DRENA: cycle 10.
  - AVALIA j: cycle 11+j.
- `pronto` cycle:
  - Win on line j: `pronto` at cycle 12+j.
  - No win: `pronto` at cycle 19.
  - `erro` case: `pronto` at cycle 1.
- Results become valid in the same cycle as `pronto` and stay stable until the next accepted start.
- `reset` low mid-operation aborts immediately, with all outputs at their reset values. The RAM is never written by this block, so an abort leaves no side effects.

## Configuration
- `VERIFICA_EMPATE_EN` defined:
  - Track the full-board condition, i.e. all 9 captured codes in {01,10}.
  - In FIM with no winner, set `empate` to the full-board value.
- `VERIFICA_EMPATE_EN` undefined:
  - `empate` is constant 0.
  - Full-board logic is not synthesized.
  - All other behaviour and timing are identical.

## Structure
- Shared package `jogo_pkg`:
  - Cell codes VAZIO/JOGADOR_X/JOGADOR_O.
  - State encoding for this block.
  - Constant table of 8 lines × 3 cell indices.
  - Constants CELULAS=9 and LINHAS=8.
- Sub-module `avalia_linha`: combinational. Takes three cell codes and returns `ganhou` plus the winning code. Instantiated once and muxed by line index.

## Test plan
- Row win: X at cells 0,1,2 of macro 0, `inicia` at cycle 0 → `ram_addr` 0..8 over cycles 1–9; `pronto` at cycle 12; `vencedor`=01.
- Late diagonal: O at cells 2,4,6 of macro 8 (addresses 74,76,78), no other line complete → first address 72; `pronto` at cycle 19; `vencedor`=10.
- Full board, no winner, pattern X O X / X O O / O X X, with `VERIFICA_EMPATE_EN` defined → `pronto` at cycle 19, `vencedor`=00, `empate`=1. With the macro undefined → `empate`=0.
- Invalid index: `macro_idx`=12 → `ram_re` never asserted; `pronto` at cycle 1; `erro`=1.
- Abort and restart:
  - `reset` low at cycle 5 → `ocupado`=0 and all outputs at reset values.
  - Re-start on macro 3 → first `ram_addr`=27.
  - `inicia` held high throughout → exactly one evaluation per ESPERA visit.
- Code 11 in cells 3,4,5 → no row-1 win; `vencedor`=00.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared game definitions: cell codes, verifier state encoding and the table
// of the 8 winning lines of a 3x3 micro-board.
package jogo_pkg;

    typedef enum logic [1:0] {
        VAZIO     = 2'b00,
        JOGADOR_X = 2'b01,
        JOGADOR_O = 2'b10
    } celula_t;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        LE     = 3'd1,
        DRENA  = 3'd2,
        AVALIA = 3'd3,
        FIM    = 3'd4
    } estado_t;

    localparam int CELULAS = 9;
    localparam int LINHAS  = 8;

    typedef logic [3:0] indice_t;

    // Rows, then columns, then the two diagonals; this order sets which win is reported first.
    localparam indice_t LINHA_TAB [LINHAS][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/avalia_linha.sv
// Combinational check of one line of three cells: wins when all three hold the
// same player code (code 11 counts as empty and never wins).
module avalia_linha
    import jogo_pkg::*;
#(
    parameter int CELL_W = 2
) (
    input  logic [CELL_W-1:0] a,
    input  logic [CELL_W-1:0] b,
    input  logic [CELL_W-1:0] c,
    output logic              ganhou,
    output logic [1:0]        codigo
);

    logic jogador;

    assign jogador = (a == CELL_W'(JOGADOR_X)) || (a == CELL_W'(JOGADOR_O));
    assign ganhou  = jogador && (a == b) && (b == c);
    assign codigo  = ganhou ? a[1:0] : 2'b00;

endmodule

// File: rtl/verificador_tabuleiro_seq.sv
// Reads one micro-board from the board RAM, one cell per cycle, then scans the
// 8 winning lines. Define VERIFICA_EMPATE_EN to also report a full-board draw.
module verificador_tabuleiro_seq
    import jogo_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int CELL_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inicia,
    input  logic [3:0]        macro_idx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [CELL_W-1:0] ram_dado,
    output logic              ocupado,
    output logic              pronto,
    output logic [1:0]        vencedor,
    output logic              empate,
    output logic              erro,
    output logic [2:0]        db_estado
);

    estado_t           estado;
    estado_t           proximo;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] idx_ext;
    logic [3:0]        k;
    logic [2:0]        j;
    logic [CELL_W-1:0] celula [CELULAS];
    logic              idx_valido;
    logic [CELL_W-1:0] la;
    logic [CELL_W-1:0] lb;
    logic [CELL_W-1:0] lc;
    logic              ganhou;
    logic [1:0]        codigo;
    logic              ultima_linha;

    assign idx_ext      = ADDR_W'(macro_idx);
    assign idx_valido   = (macro_idx <= 4'd8);
    assign ultima_linha = (j == 3'(LINHAS - 1));
    assign db_estado    = estado;

    assign la = celula[LINHA_TAB[j][0]];
    assign lb = celula[LINHA_TAB[j][1]];
    assign lc = celula[LINHA_TAB[j][2]];

    avalia_linha #(.CELL_W(CELL_W)) u_linha (
        .a      (la),
        .b      (lb),
        .c      (lc),
        .ganhou (ganhou),
        .codigo (codigo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= ESPERA;
        else        estado <= proximo;
    end

    always_comb begin
        proximo  = estado;
        ram_re   = 1'b0;
        ram_addr = '0;
        ocupado  = 1'b1;
        pronto   = 1'b0;
        case (estado)
            ESPERA: begin
                ocupado = 1'b0;
                if (inicia) proximo = idx_valido ? LE : FIM;
            end
            LE: begin
                ram_re   = 1'b1;
                ram_addr = base + ADDR_W'(k);
                if (k == 4'(CELULAS - 1)) proximo = DRENA;
            end
            DRENA:   proximo = AVALIA;
            AVALIA:  if (ganhou || ultima_linha) proximo = FIM;
            FIM: begin
                pronto  = 1'b1;
                proximo = ESPERA;
            end
            default: proximo = ESPERA;
        endcase
    end

    // RAM data lags the address by one cycle, so cell k-1 lands while address k is out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            base     <= '0;
            k        <= '0;
            j        <= '0;
            vencedor <= 2'b00;
            erro     <= 1'b0;
            for (int i = 0; i < CELULAS; i++) celula[i] <= '0;
        end else begin
            case (estado)
                ESPERA: if (inicia) begin
                    vencedor <= 2'b00;
                    k        <= '0;
                    j        <= '0;
                    if (idx_valido) begin
                        base <= (idx_ext << 3) + idx_ext;
                        erro <= 1'b0;
                    end else begin
                        erro <= 1'b1;
                    end
                end
                LE: begin
                    if (k != 4'd0) celula[k - 4'd1] <= ram_dado;
                    k <= k + 4'd1;
                end
                DRENA: begin
                    celula[CELULAS - 1] <= ram_dado;
                    j <= '0;
                end
                AVALIA: begin
                    if (ganhou) vencedor <= codigo;
                    j <= j + 3'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef VERIFICA_EMPATE_EN
    logic cheio;
    logic empate_q;

    always_comb begin
        cheio = 1'b1;
        for (int i = 0; i < CELULAS; i++) begin
            if (!((celula[i] == CELL_W'(JOGADOR_X)) || (celula[i] == CELL_W'(JOGADOR_O))))
                cheio = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            empate_q <= 1'b0;
        else if (estado == ESPERA && inicia)
            empate_q <= 1'b0;
        else if (estado == AVALIA && !ganhou && ultima_linha)
            empate_q <= cheio;
    end

    assign empate = empate_q;
`else
    assign empate = 1'b0;
`endif

endmodule

// File: tb/tb_verificador_tabuleiro_seq.sv
// Directed table-driven bench for verificador_tabuleiro_seq with a synchronous
// RAM model, plus hand-written abort/restart and held-start sequences.
module tb_verificador_tabuleiro_seq;

    localparam int ADDR_W = 7;
    localparam int CELL_W = 2;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] B = 2'b11;

`ifdef VERIFICA_EMPATE_EN
    localparam logic EMPATE_ESP = 1'b1;
`else
    localparam logic EMPATE_ESP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              inicia = 1'b0;
    logic [3:0]        macro_idx = 4'd0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic [CELL_W-1:0] ram_dado = '0;
    logic              ocupado;
    logic              pronto;
    logic [1:0]        vencedor;
    logic              empate;
    logic              erro;
    logic [2:0]        db_estado;

    logic [1:0] mem [81];

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0]  idx;
        logic [17:0] cel;
        logic [4:0]  pronto_ciclo;
        logic [1:0]  venc;
        logic        empate;
        logic        erro;
    } vetor_t;

    vetor_t vetores [9];

    verificador_tabuleiro_seq #(.ADDR_W(ADDR_W), .CELL_W(CELL_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .inicia    (inicia),
        .macro_idx (macro_idx),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_dado  (ram_dado),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .vencedor  (vencedor),
        .empate    (empate),
        .erro      (erro),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (ram_re) ram_dado <= mem[ram_addr];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [17:0] tab(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                                         input logic [1:0] c3, input logic [1:0] c4, input logic [1:0] c5,
                                         input logic [1:0] c6, input logic [1:0] c7, input logic [1:0] c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic checkOutput(input string nome, input int obtido, input int esperado);
        tests++;
        if (obtido != esperado) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, obtido, esperado);
        end
    endtask

    // Background of X everywhere so a wrong address shows up as a wrong result.
    task automatic loadBoard(input logic [3:0] idx, input logic [17:0] cel);
        for (int a = 0; a < 81; a++) mem[a] = X;
        if (idx <= 4'd8)
            for (int i = 0; i < 9; i++) mem[int'(idx) * 9 + i] = cel[2*i +: 2];
    endtask

    // Cycle 0 is the ESPERA cycle with inicia high; returns while still in the pronto cycle.
    task automatic applyStimulus(input logic [3:0] idx, input bit segura,
                                 output int ciclo_pronto, output int prim_addr,
                                 output int n_re, output int erros_addr);
        ciclo_pronto = -1;
        prim_addr    = -1;
        n_re         = 0;
        erros_addr   = 0;
        @(posedge clock); #1;
        macro_idx = idx;
        inicia    = 1'b1;
        for (int c = 1; c <= 40 && ciclo_pronto < 0; c++) begin
            @(posedge clock); #1;
            if (!segura) inicia = 1'b0;
            if (ram_re) begin
                if (prim_addr < 0) prim_addr = int'(ram_addr);
                if (int'(ram_addr) != int'(idx) * 9 + n_re) erros_addr++;
                n_re++;
            end
            if (pronto) ciclo_pronto = c;
        end
    endtask

    initial begin
        int cp, pa, nr, ea;
        vetor_t v;

        vetores[0] = '{idx: 4'd0,  cel: tab(X,X,X, O,O,E, E,E,E), pronto_ciclo: 5'd12, venc: X, empate: 1'b0, erro: 1'b0};
        vetores[1] = '{idx: 4'd8,  cel: tab(X,E,O, E,O,X, O,X,E), pronto_ciclo: 5'd19, venc: O, empate: 1'b0, erro: 1'b0};
        vetores[2] = '{idx: 4'd4,  cel: tab(X,O,X, X,O,O, O,X,X), pronto_ciclo: 5'd19, venc: E, empate: EMPATE_ESP, erro: 1'b0};
        vetores[3] = '{idx: 4'd1,  cel: tab(X,O,X, B,B,B, O,X,O), pronto_ciclo: 5'd19, venc: E, empate: 1'b0, erro: 1'b0};
        vetores[4] = '{idx: 4'd5,  cel: tab(E,O,X, X,O,E, E,O,X), pronto_ciclo: 5'd16, venc: O, empate: 1'b0, erro: 1'b0};
        vetores[5] = '{idx: 4'd2,  cel: tab(X,O,E, O,X,E, E,E,X), pronto_ciclo: 5'd18, venc: X, empate: 1'b0, erro: 1'b0};
        vetores[6] = '{idx: 4'd7,  cel: tab(X,X,X, O,O,X, X,O,O), pronto_ciclo: 5'd12, venc: X, empate: 1'b0, erro: 1'b0};
        vetores[7] = '{idx: 4'd12, cel: tab(X,X,X, X,X,X, X,X,X), pronto_ciclo: 5'd1,  venc: E, empate: 1'b0, erro: 1'b1};
        vetores[8] = '{idx: 4'd9,  cel: tab(O,O,O, O,O,O, O,O,O), pronto_ciclo: 5'd1,  venc: E, empate: 1'b0, erro: 1'b1};

        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_ram_addr", int'(ram_addr), 0);
        checkOutput("reset_ram_re", int'(ram_re), 0);
        checkOutput("reset_ocupado", int'(ocupado), 0);
        checkOutput("reset_pronto", int'(pronto), 0);
        checkOutput("reset_vencedor", int'(vencedor), 0);
        checkOutput("reset_empate", int'(empate), 0);
        checkOutput("reset_erro", int'(erro), 0);
        checkOutput("reset_db_estado", int'(db_estado), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            v = vetores[i];
            loadBoard(v.idx, v.cel);
            applyStimulus(v.idx, 1'b0, cp, pa, nr, ea);
            checkOutput($sformatf("v%0d_pronto_ciclo", i), cp, int'(v.pronto_ciclo));
            checkOutput($sformatf("v%0d_vencedor", i), int'(vencedor), int'(v.venc));
            checkOutput($sformatf("v%0d_empate", i), int'(empate), int'(v.empate));
            checkOutput($sformatf("v%0d_erro", i), int'(erro), int'(v.erro));
            checkOutput($sformatf("v%0d_prim_addr", i), pa, v.erro ? -1 : int'(v.idx) * 9);
            checkOutput($sformatf("v%0d_n_re", i), nr, v.erro ? 0 : 9);
            checkOutput($sformatf("v%0d_addr_seq_erros", i), ea, 0);
            @(posedge clock); #1;
            checkOutput($sformatf("v%0d_pronto_pulso", i), int'(pronto), 0);
            checkOutput($sformatf("v%0d_volta_espera", i), int'(db_estado), 0);
            repeat (2) @(posedge clock);
            #1;
            checkOutput($sformatf("v%0d_vencedor_retido", i), int'(vencedor), int'(v.venc));
            checkOutput($sformatf("v%0d_erro_retido", i), int'(erro), int'(v.erro));
            checkOutput($sformatf("v%0d_empate_retido", i), int'(empate), int'(v.empate));
        end

        // Abort in the middle of LE: everything drops back to reset values at once.
        loadBoard(4'd0, vetores[0].cel);
        @(posedge clock); #1;
        macro_idx = 4'd0;
        inicia    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clock); #1;
            inicia = 1'b0;
        end
        checkOutput("abort_antes_estado", int'(db_estado), 1);
        reset = 1'b0;
        #1;
        checkOutput("abort_ocupado", int'(ocupado), 0);
        checkOutput("abort_ram_re", int'(ram_re), 0);
        checkOutput("abort_ram_addr", int'(ram_addr), 0);
        checkOutput("abort_db_estado", int'(db_estado), 0);
        checkOutput("abort_pronto", int'(pronto), 0);
        checkOutput("abort_vencedor", int'(vencedor), 0);
        checkOutput("abort_erro", int'(erro), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Restart on macro 3 with inicia held high across two ESPERA visits.
        loadBoard(4'd3, tab(E,E,E, X,X,E, O,O,O));
        applyStimulus(4'd3, 1'b1, cp, pa, nr, ea);
        checkOutput("restart_prim_addr", pa, 27);
        checkOutput("restart_pronto_ciclo", cp, 14);
        checkOutput("restart_vencedor", int'(vencedor), 2);
        checkOutput("restart_n_re", nr, 9);
        applyStimulus(4'd3, 1'b1, cp, pa, nr, ea);
        checkOutput("segura_prim_addr", pa, 27);
        checkOutput("segura_pronto_ciclo", cp, 14);
        checkOutput("segura_n_re", nr, 9);
        checkOutput("segura_addr_seq_erros", ea, 0);
        inicia = 1'b0;
        @(posedge clock); #1;
        checkOutput("segura_espera", int'(db_estado), 0);
        @(posedge clock); #1;
        checkOutput("segura_fica_espera", int'(db_estado), 0);
        checkOutput("segura_ocupado", int'(ocupado), 0);
        checkOutput("segura_vencedor_retido", int'(vencedor), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
